// File: rtl/rd_chunk_scheduler.sv
// Splits one host read job into read-SM runs of at most MAX_CHUNK lines and
// launches them one at a time, gated by consumer buffer space.
module rd_chunk_scheduler #(
  parameter int unsigned ADDR_W    = 42,
  parameter int unsigned MAX_CHUNK = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_clAddr,
  input  logic [63:0]       total_lines,
  output logic              busy,
  output logic              job_done,
  output logic              job_aborted,
  input  logic              consumer_ready,
  output logic              sm_run,
  output logic [ADDR_W-1:0] sm_first_clAddr,
  output logic [63:0]       sm_data_length,
  input  logic              sm_done,
  output logic [31:0]       chunks_issued,
  output logic [63:0]       lines_completed
);

  typedef enum logic [1:0] {IDLE, LAUNCH, ARM, WAIT_DONE} state_t;

  localparam logic [63:0] MAX_LEN = 64'(MAX_CHUNK);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [63:0]       remaining, remaining_nxt;
  logic              abort_flag, abort_flag_nxt;

  logic              busy_nxt, job_done_nxt, job_aborted_nxt, sm_run_nxt;
  logic [ADDR_W-1:0] sm_first_nxt;
  logic [63:0]       sm_len_nxt;
  logic [31:0]       chunks_nxt;
  logic [63:0]       lines_nxt;

  logic              abort_eff;
  logic [63:0]       rem_after;

  always_comb begin
    state_nxt       = state;
    cur_addr_nxt    = cur_addr;
    remaining_nxt   = remaining;
    abort_flag_nxt  = abort_flag;
    job_done_nxt    = 1'b0;
    job_aborted_nxt = job_aborted;
    sm_run_nxt      = 1'b0;
    sm_first_nxt    = sm_first_clAddr;
    sm_len_nxt      = sm_data_length;
    chunks_nxt      = chunks_issued;
    lines_nxt       = lines_completed;
    // an abort arriving on a decision cycle counts immediately
    abort_eff       = abort_flag | abort;
    rem_after       = remaining - sm_data_length;

    case (state)
      IDLE: begin
        if (start) begin
          cur_addr_nxt    = base_clAddr;
          remaining_nxt   = total_lines;
          chunks_nxt      = '0;
          lines_nxt       = '0;
          job_aborted_nxt = 1'b0;
          abort_flag_nxt  = 1'b0;
          if (total_lines == 64'd0) begin
            job_done_nxt = 1'b1;
          end else begin
            abort_flag_nxt = abort;
            state_nxt      = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        abort_flag_nxt = abort_eff;
        if (abort_eff) begin
          state_nxt       = IDLE;
          job_done_nxt    = 1'b1;
          job_aborted_nxt = 1'b1;
        end else if (consumer_ready) begin
          sm_first_nxt = cur_addr;
          sm_len_nxt   = (remaining > MAX_LEN) ? MAX_LEN : remaining;
          sm_run_nxt   = 1'b1;
          chunks_nxt   = chunks_issued + 32'd1;
          state_nxt    = ARM;
        end
      end
      ARM: begin
        // read SM still shows done from the previous run here; don't look at it
        abort_flag_nxt = abort_eff;
        state_nxt      = WAIT_DONE;
      end
      WAIT_DONE: begin
        abort_flag_nxt = abort_eff;
        if (sm_done) begin
          lines_nxt     = lines_completed + sm_data_length;
          remaining_nxt = rem_after;
          cur_addr_nxt  = cur_addr + ADDR_W'(sm_data_length);
          if (rem_after == 64'd0 || abort_eff) begin
            state_nxt       = IDLE;
            job_done_nxt    = 1'b1;
            job_aborted_nxt = abort_eff && (rem_after != 64'd0);
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cur_addr        <= '0;
      remaining       <= '0;
      abort_flag      <= 1'b0;
      busy            <= 1'b0;
      job_done        <= 1'b0;
      job_aborted     <= 1'b0;
      sm_run          <= 1'b0;
      sm_first_clAddr <= '0;
      sm_data_length  <= '0;
      chunks_issued   <= '0;
      lines_completed <= '0;
    end else begin
      state           <= state_nxt;
      cur_addr        <= cur_addr_nxt;
      remaining       <= remaining_nxt;
      abort_flag      <= abort_flag_nxt;
      busy            <= busy_nxt;
      job_done        <= job_done_nxt;
      job_aborted     <= job_aborted_nxt;
      sm_run          <= sm_run_nxt;
      sm_first_clAddr <= sm_first_nxt;
      sm_data_length  <= sm_len_nxt;
      chunks_issued   <= chunks_nxt;
      lines_completed <= lines_nxt;
    end
  end

endmodule

// File: tb/tb_rd_chunk_scheduler.sv
// Bench for rd_chunk_scheduler: job-level model checked every cycle, plus
// directed scenarios with hand-computed chunk lists.
`timescale 1ns/1ps
module tb_rd_chunk_scheduler;
  localparam int ADDR_W = 42;
  localparam int MAXC   = 64;
  localparam int SM_LAT = 3;

  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, ready = 1, sm_done = 1;
  logic [ADDR_W-1:0] base = '0;
  logic [63:0] total = '0;
  logic busy, job_done, job_aborted, sm_run;
  logic [ADDR_W-1:0] sm_first;
  logic [63:0] sm_len, lines_completed;
  logic [31:0] chunks_issued;

  // second instance with MAX_CHUNK=4 for the wrap case
  logic s_start = 0, s_done = 1;
  logic [ADDR_W-1:0] s_base = '0;
  logic [63:0] s_total = '0;
  logic s_busy, s_job_done, s_job_aborted, s_run;
  logic [ADDR_W-1:0] s_first;
  logic [63:0] s_len, s_lines;
  logic [31:0] s_chunks;

  always #5 clk = ~clk;

  rd_chunk_scheduler #(.ADDR_W(ADDR_W), .MAX_CHUNK(MAXC)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .base_clAddr(base), .total_lines(total), .busy(busy), .job_done(job_done),
    .job_aborted(job_aborted), .consumer_ready(ready), .sm_run(sm_run),
    .sm_first_clAddr(sm_first), .sm_data_length(sm_len), .sm_done(sm_done),
    .chunks_issued(chunks_issued), .lines_completed(lines_completed));

  rd_chunk_scheduler #(.ADDR_W(ADDR_W), .MAX_CHUNK(4)) dut_s (
    .clk(clk), .reset(rst_n), .start(s_start), .abort(1'b0),
    .base_clAddr(s_base), .total_lines(s_total), .busy(s_busy), .job_done(s_job_done),
    .job_aborted(s_job_aborted), .consumer_ready(1'b1), .sm_run(s_run),
    .sm_first_clAddr(s_first), .sm_data_length(s_len), .sm_done(s_done),
    .chunks_issued(s_chunks), .lines_completed(s_lines));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // read-SM stand-ins: done drops after a run, returns SM_LAT cycles later
  int sm_cnt = 0, s_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin sm_done = 1; sm_cnt = 0; end
    else if (sm_run) begin sm_done = 0; sm_cnt = SM_LAT; end
    else if (sm_cnt > 0) begin sm_cnt--; if (sm_cnt == 0) sm_done = 1; end
  end
  always @(negedge clk) begin
    if (!rst_n) begin s_done = 1; s_cnt = 0; end
    else if (s_run) begin s_done = 0; s_cnt = SM_LAT; end
    else if (s_cnt > 0) begin s_cnt--; if (s_cnt == 0) s_done = 1; end
  end

  // job-level model: remaining lines, next address, chunk in flight
  logic m_active = 0, m_flight = 0, m_arm = 0, m_abreq = 0, m_ab_last = 0;
  logic [ADDR_W-1:0] m_addr = '0, m_first = '0;
  logic [63:0] m_rem = '0, m_len = '0, m_lines = '0;
  logic [31:0] m_issued = '0;
  logic [ADDR_W-1:0] run_addr_q[$];
  logic [63:0] run_len_q[$];

  always @(posedge clk) begin
    logic exp_run, exp_done;
    #1;
    exp_run = 0; exp_done = 0;
    if (!rst_n) begin
      m_active = 0; m_flight = 0; m_arm = 0; m_abreq = 0; m_ab_last = 0;
      m_addr = '0; m_first = '0; m_rem = '0; m_len = '0; m_lines = '0; m_issued = '0;
    end else if (!m_active) begin
      if (start) begin
        m_issued = 0; m_lines = 0; m_ab_last = 0;
        if (total == 0) exp_done = 1;
        else begin
          m_active = 1; m_rem = total; m_addr = base; m_abreq = abort; m_flight = 0;
        end
      end
    end else begin
      m_abreq = m_abreq | abort;
      if (!m_flight) begin
        if (m_abreq) begin
          exp_done = 1; m_ab_last = 1; m_active = 0;
        end else if (ready) begin
          exp_run = 1; m_first = m_addr;
          m_len = (m_rem < 64'(MAXC)) ? m_rem : 64'(MAXC);
          m_issued++; m_flight = 1; m_arm = 1;
        end
      end else if (m_arm) begin
        m_arm = 0;
      end else if (sm_done) begin
        m_lines = m_lines + m_len;
        m_rem = m_rem - m_len;
        m_addr = m_addr + m_len[ADDR_W-1:0];
        m_flight = 0;
        if (m_rem == 0 || m_abreq) begin
          exp_done = 1; m_ab_last = m_abreq && (m_rem != 0); m_active = 0;
        end
      end
    end
    chk("sm_run", sm_run, exp_run);
    chk("job_done", job_done, exp_done);
    chk("busy", busy, m_active);
    chk("job_aborted", job_aborted, m_ab_last);
    chk("chunks_issued", chunks_issued, m_issued);
    chk("lines_completed", lines_completed, m_lines);
    chk("sm_first_clAddr", sm_first, m_first);
    chk("sm_data_length", sm_len, m_len);
    if (sm_run) begin
      run_addr_q.push_back(sm_first);
      run_len_q.push_back(sm_len);
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [63:0] t, input logic ab);
    base = b; total = t; start = 1; abort = ab;
    @(negedge clk);
    start = 0; abort = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (job_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk({name, "_done_seen"}, job_done, 1);
  endtask

  task automatic wait_run(input string name, input int budget);
    int n = 0;
    while (sm_run !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk({name, "_run_seen"}, sm_run, 1);
  endtask

  task automatic clear_log();
    run_addr_q.delete();
    run_len_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_run", sm_run, 0);
    chk("rst_done", job_done, 0);
    chk("rst_len", sm_len, 0);
    rst_n = 1;
    @(negedge clk);

    // 1: single short chunk
    clear_log();
    pulse_start(42'h1000, 10, 0);
    wait_done("t1", 100);
    chk("t1_nruns", run_len_q.size(), 1);
    chk("t1_addr0", run_addr_q[0], 42'h1000);
    chk("t1_len0", run_len_q[0], 10);
    chk("t1_chunks", chunks_issued, 1);
    chk("t1_lines", lines_completed, 10);
    chk("t1_aborted", job_aborted, 0);
    @(negedge clk);

    // 2: 150 lines -> 64, 64, 22
    clear_log();
    pulse_start(42'h1000, 150, 0);
    wait_done("t2", 400);
    chk("t2_nruns", run_len_q.size(), 3);
    chk("t2_addr0", run_addr_q[0], 42'h1000);
    chk("t2_addr1", run_addr_q[1], 42'h1040);
    chk("t2_addr2", run_addr_q[2], 42'h1080);
    chk("t2_len0", run_len_q[0], 64);
    chk("t2_len1", run_len_q[1], 64);
    chk("t2_len2", run_len_q[2], 22);
    chk("t2_chunks", chunks_issued, 3);
    chk("t2_lines", lines_completed, 150);
    chk("t2_aborted", job_aborted, 0);
    @(negedge clk);

    // 3: empty job
    clear_log();
    pulse_start(42'h0, 0, 0);
    chk("t3_done", job_done, 1);
    chk("t3_aborted", job_aborted, 0);
    chk("t3_chunks", chunks_issued, 0);
    @(negedge clk);
    chk("t3_done_pulse", job_done, 0);
    chk("t3_nruns", run_len_q.size(), 0);

    // 4: abort during the first chunk's wait
    clear_log();
    pulse_start(42'h2000, 150, 0);
    wait_run("t4", 50);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done("t4", 100);
    chk("t4_aborted", job_aborted, 1);
    chk("t4_lines", lines_completed, 64);
    chk("t4_chunks", chunks_issued, 1);
    chk("t4_nruns", run_len_q.size(), 1);
    @(negedge clk);

    // start and abort together: ends before any chunk, 2 cycles after start
    clear_log();
    pulse_start(42'h5000, 20, 1);
    chk("sa_busy", busy, 1);
    chk("sa_done_early", job_done, 0);
    @(negedge clk);
    chk("sa_done", job_done, 1);
    chk("sa_aborted", job_aborted, 1);
    chk("sa_nruns", run_len_q.size(), 0);
    @(negedge clk);

    // 5: consumer not ready for 20 cycles, stray start ignored
    clear_log();
    ready = 0;
    pulse_start(42'h3000, 5, 0);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      if (i == 5) begin base = 42'hDEAD; total = 77; end
      @(negedge clk);
      chk("t5_norun", sm_run, 0);
    end
    start = 0;
    ready = 1;
    @(negedge clk);
    chk("t5_run_after_ready", sm_run, 1);
    chk("t5_first", sm_first, 42'h3000);
    wait_done("t5", 100);
    chk("t5_len", run_len_q[0], 5);
    chk("t5_lines", lines_completed, 5);
    chk("t5_nruns", run_len_q.size(), 1);
    @(negedge clk);

    // 6a: address wrap on the 64-line instance
    clear_log();
    pulse_start(42'h3FFFFFFFFC0, 100, 0);
    wait_done("t6a", 200);
    chk("t6a_nruns", run_len_q.size(), 2);
    chk("t6a_addr1", run_addr_q[1], 42'h0);
    chk("t6a_len1", run_len_q[1], 36);
    @(negedge clk);

    // 6b: wrap with MAX_CHUNK=4
    begin
      int n;
      s_base = 42'h3FFFFFFFFFC; s_total = 8; s_start = 1;
      @(negedge clk);
      s_start = 0;
      n = 0;
      while (s_run !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("t6b_run0", s_run, 1);
      chk("t6b_first0", s_first, 42'h3FFFFFFFFFC);
      chk("t6b_len0", s_len, 4);
      @(negedge clk);
      n = 0;
      while (s_run !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("t6b_run1", s_run, 1);
      chk("t6b_first1", s_first, 42'h0);
      chk("t6b_len1", s_len, 4);
      n = 0;
      while (s_job_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("t6b_done", s_job_done, 1);
      chk("t6b_lines", s_lines, 8);
      chk("t6b_chunks", s_chunks, 2);
      chk("t6b_aborted", s_job_aborted, 0);
      @(negedge clk);
    end

    // 6c: reset in the middle of a chunk
    clear_log();
    pulse_start(42'h4000, 150, 0);
    wait_run("t6c", 50);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6c_busy", busy, 0);
    chk("t6c_done", job_done, 0);
    chk("t6c_chunks", chunks_issued, 0);
    chk("t6c_lines", lines_completed, 0);
    chk("t6c_first", sm_first, 0);
    chk("t6c_len", sm_len, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);
    clear_log();
    pulse_start(42'h6000, 10, 0);
    wait_done("t6c_after", 100);
    chk("t6c_after_lines", lines_completed, 10);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
